keygen_mq_montred: RTL and testbench

Pipelined Montgomery reduction stage for Falcon key generation, modulus q = 12289, R = 2^16. It sits directly downstream of the 17s×16ns signed multiplier. It consumes the 32-bit signed product z and produces r = z·R⁻¹ mod q, canonical in [0, q). It uses a valid/ready handshake with global stall and flags out-of-range products.

---
 rtl/falcon_mq_pkg.sv | 14 +
 rtl/mq_canon.sv | 29 ++
 rtl/keygen_mq_montred.sv | 119 +++++++++++
 tb/tb_keygen_mq_montred.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/falcon_mq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// falcon_mq_pkg : shared constants and types for mod-q arithmetic, q = 12289
// Rev 1.0
// ----------------------------------------------------------------------------
package falcon_mq_pkg;
    localparam int Q     = 12289;
    localparam int Q0I   = 12287;
    localparam int R_LOG = 16;

    typedef logic [13:0]        mq_t;
    typedef logic signed [31:0] prod_t;
endpackage
`default_nettype wire

// File: rtl/mq_canon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mq_canon : one-step correction of t in (-q, 2q) into canonical [0, q)
// Rev 1.0
// ----------------------------------------------------------------------------
module mq_canon #(
    parameter int Q = falcon_mq_pkg::Q
) (
    input  logic signed [16:0] i_t,
    output logic [13:0]        o_r
);
    import falcon_mq_pkg::*;

    localparam logic signed [16:0] c_q = 17'(Q);

    logic signed [16:0] w_fix;

    always_comb begin
        w_fix = i_t;
        if (i_t < 0) begin
            w_fix = i_t + c_q;
        end else if (i_t >= c_q) begin
            w_fix = i_t - c_q;
        end
    end

    assign o_r = 14'(w_fix);
endmodule
`default_nettype wire

// File: rtl/keygen_mq_montred.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keygen_mq_montred : pipelined Montgomery reduction r = z * 2^-16 mod q
// Rev 1.0
// ----------------------------------------------------------------------------
module keygen_mq_montred #(
    parameter int Q   = falcon_mq_pkg::Q,
    parameter int Q0I = falcon_mq_pkg::Q0I
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_r,
    input  logic        err_clr,
    output logic        range_err
);
    import falcon_mq_pkg::*;

    localparam prod_t c_lim = prod_t'(32'(Q) << R_LOG);

    logic               w_adv;
    prod_t              w_z;
    logic               w_rng;
    logic [15:0]        w_m;
    logic [31:0]        w_mq;
    logic signed [32:0] w_sum;
    logic signed [16:0] w_t;
    mq_t                w_r;

    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    prod_t              z1_q, z1_d, z2_q, z2_d;
    logic [15:0]        m2_q, m2_d;
    logic signed [16:0] t3_q, t3_d;
    mq_t                out_r_q, out_r_d;
    logic               out_valid_q, out_valid_d;
    logic               range_err_q, range_err_d;

    assign w_adv = !out_valid_q || out_ready;
    assign w_z   = in_z;
    assign w_rng = (w_z >= c_lim) || (w_z <= -c_lim);

    // m makes z + m*q divisible by 2^16, so the shift below is exact.
    assign w_m   = 16'(32'(z1_q[15:0]) * 32'(Q0I));
    assign w_mq  = 32'(m2_q) * 32'(Q);
    assign w_sum = $signed({z2_q[31], z2_q}) + $signed({1'b0, w_mq});
    assign w_t   = 17'(w_sum >>> R_LOG);

    mq_canon #(.Q(Q)) u_canon (
        .i_t (t3_q),
        .o_r (w_r)
    );

    always_comb begin
        v1_d        = v1_q;
        z1_d        = z1_q;
        v2_d        = v2_q;
        z2_d        = z2_q;
        m2_d        = m2_q;
        v3_d        = v3_q;
        t3_d        = t3_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        range_err_d = range_err_q;

        // Data registers load only for valid words; bubbles move just the v-bits.
        if (w_adv) begin
            v1_d = in_valid;
            if (in_valid) z1_d = w_z;
            v2_d = v1_q;
            if (v1_q) begin
                z2_d = z1_q;
                m2_d = w_m;
            end
            v3_d = v2_q;
            if (v2_q) t3_d = w_t;
            out_valid_d = v3_q;
            if (v3_q) out_r_d = w_r;
        end

        if (err_clr) range_err_d = 1'b0;
        if (in_valid && w_adv && w_rng) range_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q        <= 1'b0;
            z1_q        <= '0;
            v2_q        <= 1'b0;
            z2_q        <= '0;
            m2_q        <= '0;
            v3_q        <= 1'b0;
            t3_q        <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            range_err_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            z1_q        <= z1_d;
            v2_q        <= v2_d;
            z2_q        <= z2_d;
            m2_q        <= m2_d;
            v3_q        <= v3_d;
            t3_q        <= t3_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign range_err = range_err_q;
endmodule
`default_nettype wire

// File: tb/tb_keygen_mq_montred.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_keygen_mq_montred : scoreboard bench for the Montgomery reduction stage
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_keygen_mq_montred;
    localparam int     Q   = 12289;
    localparam longint LIM = 64'(Q) * 65536;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic [31:0] in_z = '0;
    logic        in_ready, out_valid, range_err;
    logic [13:0] out_r;

    typedef struct {
        int unsigned exp;
        bit          dc;
        longint      acc;
        bit          strict;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    longint      rinv = 0;
    longint      lat;
    bit          tog = 1'b0;
    bit          stall_prev = 1'b0;
    logic [13:0] prev_r = '0;

    keygen_mq_montred dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .err_clr   (err_clr),
        .range_err (range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int unsigned ref_r(input longint z);
        longint a;
        a = z % Q;
        if (a < 0) a += Q;
        return int'((a * rinv) % Q);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n, input logic ordy, input logic clr);
        in_valid  = 1'b0;
        out_ready = ordy;
        err_clr   = clr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        err_clr = 1'b0;
    endtask

    // mode 0: out_ready=1, 1: random, 2: toggling, 3: out_ready=0
    task automatic send(input longint z, input int mode, input logic clr);
        exp_t e;
        bit   done;
        done     = 1'b0;
        e.dc     = (z >= LIM) || (z <= -LIM);
        e.exp    = e.dc ? 0 : ref_r(z);
        e.strict = (mode == 0);
        e.acc    = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            in_valid = 1'b1;
            in_z     = 32'(z);
            err_clr  = clr;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(9, 0) < 7);
                2:       begin out_ready = tog; tog = ~tog; end
                default: out_ready = 1'b0;
            endcase
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.acc = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        err_clr  = 1'b0;
        chk("accept_timeout", longint'(done), 1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL handshake: in_ready=%b out_valid=%b out_ready=%b",
                         in_ready, out_valid, out_ready);
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== prev_r) begin
                    failures++;
                    $display("FAIL stall_hold: out_valid=%b out_r=%0d required valid=1 r=%0d",
                             out_valid, out_r, prev_r);
                end
            end
            if (out_valid === 1'b1 && !stall_prev) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: out_r=%0d with empty scoreboard", out_r);
                end else begin
                    lat = cyc - sb[0].acc;
                    if (sb[0].strict ? (lat != 3) : (lat < 3)) begin
                        failures++;
                        $display("FAIL latency: got %0d required %s3", lat,
                                 sb[0].strict ? "" : ">=");
                    end
                    checks++;
                    if (!sb[0].dc && out_r !== 14'(sb[0].exp)) begin
                        failures++;
                        $display("FAIL data: got %0d expected %0d", out_r, sb[0].exp);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() > 0) sb.delete(0);
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_r     = out_r;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint z;
        for (int x = 0; x < Q; x++) begin
            if ((longint'(x) * 65536) % Q == 1) rinv = x;
        end

        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_range_err", range_err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        send(65536, 0, 0);
        send(196608, 0, 0);
        send(0, 0, 0);
        send(12289, 0, 0);
        send(-65536, 0, 0);
        send(805306368, 0, 0);
        idle(6, 1, 0);

        chk("rerr_clean", range_err, 0);
        send(805371904, 0, 0);
        chk("rerr_set", range_err, 1);
        idle(4, 1, 0);
        chk("rerr_sticky", range_err, 1);
        idle(1, 1, 1);
        chk("rerr_clr", range_err, 0);
        send(805371904, 0, 1);
        chk("rerr_set_over_clr", range_err, 1);
        idle(1, 1, 1);
        chk("rerr_clr2", range_err, 0);
        send(-805371904, 0, 0);
        chk("rerr_neg", range_err, 1);
        idle(1, 1, 1);
        send(805371903, 0, 0);
        send(-805371903, 0, 0);
        chk("rerr_inrange", range_err, 0);
        idle(6, 1, 0);

        // three words in flight, output stalled, then asynchronous reset
        send(327680, 3, 0);
        send(7, 3, 0);
        send(9, 3, 0);
        idle(2, 0, 0);
        chk("stall_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("postrst_in_ready", in_ready, 1);
        send(4242 * 65536 + 17, 0, 0);
        idle(6, 1, 0);

        tog = 1'b1;
        for (int i = 0; i < 24; i++) send(longint'($urandom_range(32'd1000000, 0)), 2, 0);
        idle(8, 1, 0);

        for (int i = 0; i < 10000; i++) begin
            if (i % 16 == 0) z = longint'($urandom_range(32'd200000, 0)) - 100000;
            else z = longint'($urandom_range(32'd1610743806, 0)) - 805371903;
            send(z, 1, 0);
        end

        for (int k = 0; k < 200 && sb.size() > 0; k++) idle(1, 1, 0);
        chk("drain_empty", sb.size(), 0);
        chk("final_range_err", range_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
